imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Sequences and shares the single-port, synchronous-read instruction memory between two requesters: the IF-stage fetch port and a debug/loader port.
- A boot FSM holds the core off while the loader writes the program. After boot, fetch has priority, but an aging counter guarantees the debug port is served.
- Out-of-range fetches return a NOP without touching memory.
- Sits between the IF stage and the instruction memory array.

Parameters:
- DEPTH, 256, number of 32-bit words in instruction memory
- AW, 8, word-index width (log2 DEPTH)
- MAX_WAIT, 4, cycles a debug request may be denied before it gets priority
- NOP_WORD, 32'h00000013, word returned for out-of-range fetch (addi x0,x0,0)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- boot_done  in  1  one-cycle pulse from loader: program loaded
- core_hold  out  1  high while in BOOT; core must not fetch
- fetch_req  in  1  fetch read request
- fetch_addr  in  32  byte address
- fetch_gnt  out  1  combinational grant, same cycle as fetch_req
- fetch_rvalid  out  1  read data valid, one cycle after grant
- fetch_rdata  out  32  instruction word
- fetch_err  out  1  with fetch_rvalid: misaligned address (addr[1:0]!=0)
- dbg_req  in  1  debug/loader request
- dbg_we  in  1  1=write, 0=read
- dbg_addr  in  32  byte address
- dbg_wdata  in  32  write data
- dbg_gnt  out  1  combinational grant
- dbg_rvalid  out  1  completion, one cycle after grant (reads and writes)
- dbg_rdata  out  32  read data (0 for writes)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  word index = addr[AW+1:2]
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory data, valid the cycle after mem_en (registered read)

Behaviour:
- Reset (rst=1 at clock edge) takes effect next cycle:
  - state=BOOT, core_hold=1, wait_cnt=0.
  - All rvalid/err outputs=0 and rdata outputs=0.
  - Any in-flight read is discarded. No rvalid follows an access granted in the reset cycle.
- FSM BOOT:
  - Only dbg is granted (dbg_gnt=dbg_req). fetch_gnt=0.
  - boot_done=1 moves to RUN next cycle. A dbg access in the same cycle still completes.
- FSM RUN:
  - core_hold=0. Stays in RUN until rst. boot_done is ignored.
- Arbitration in RUN, at most one grant per cycle:
  - Default: fetch wins if fetch_req.
  - dbg wins if !fetch_req, or if wait_cnt==MAX_WAIT.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle dbg_req=1 and dbg_gnt=0.
  - Clears on dbg grant or when dbg_req=0.
- Granted access:
  - mem_en=1, mem_we=dbg_we (fetch always read), mem_addr=word index, same cycle.
  - mem_en=0, mem_we=0 when nothing is granted.
- Range check (both ports): an address is out of range when addr>>2 >= DEPTH.
  - No memory access (mem_en=0).
  - Read: returns NOP_WORD (fetch) or 0 (dbg) on the next-cycle rvalid.
  - Write: dropped, still acked with dbg_rvalid.
- Misaligned fetch:
  - Memory is accessed at the truncated index.
  - fetch_rdata=mem_rdata with fetch_err=1.
  - Misaligned dbg accesses are treated as truncated, no error.
- Response registers:
  - fetch_rvalid/dbg_rvalid = registered grant (single cycle).
  - rdata is held until the next rvalid.
- Write-then-read of the same word on consecutive cycles returns the new data; the memory is write-first or accessed in separate cycles.
- A requester must hold req and its address until it sees gnt. The arbiter does not buffer requests.

Test Plan:
- Reset, dbg writes 0x00500093 to addr 0x0, boot_done -> core_hold drops cycle after pulse; fetch addr 0x0 gives fetch_rvalid next cycle with rdata 0x00500093, fetch_err=0.
- In BOOT, fetch_req=1 on addr 0x4 for 10 cycles -> fetch_gnt stays 0, mem_en only for dbg requests.
- RUN, fetch_req held high and dbg read continuously -> dbg_gnt on the 5th cycle (after 4 denials); fetch denied that cycle; fetch regranted next cycle.
- Fetch addr 0x400 (word 256, DEPTH=256) -> mem_en=0, fetch_rvalid next cycle with rdata 0x00000013; dbg write to 0x400 acked, memory unchanged.
- Fetch addr 0x6 -> mem_addr=1, fetch_err=1 with rvalid.
- Assert rst the cycle after a fetch grant -> no fetch_rvalid, core_hold=1, wait_cnt=0, FSM back in BOOT.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port synchronous-read instruction memory between IF fetch and a debug/loader port
//   clk, rst                      : clock, synchronous active-high reset
//   boot_done, core_hold          : loader handshake; core held off while booting
//   fetch_req/addr/gnt/rvalid/rdata/err : IF-stage read port
//   dbg_req/we/addr/wdata/gnt/rvalid/rdata : debug/loader read/write port
//   mem_en/we/addr/wdata/rdata    : instruction memory interface (registered read)
module imem_arbiter #(
  parameter int          DEPTH    = 256,
  parameter int          AW       = 8,
  parameter int          MAX_WAIT = 4,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_done,
  output logic          core_hold,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [31:0]   dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  typedef enum logic {BOOT, RUN} state_t;
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          boot, f_oor, d_oor, f_nop_q, d_zero_q;
  logic [31:0]   f_hold, d_hold;
  logic          unused_dbg_lsb;
  assign unused_dbg_lsb = ^dbg_addr[1:0];
  assign boot  = state == BOOT;
  assign f_oor = fetch_addr[31:2] >= 30'(DEPTH);
  assign d_oor = dbg_addr[31:2] >= 30'(DEPTH);
  // debug owns the memory during boot; afterwards it wins when fetch is idle or it has aged out
  assign dbg_gnt   = dbg_req && (boot || !fetch_req || wait_cnt == WW'(MAX_WAIT));
  assign fetch_gnt = fetch_req && !boot && !dbg_gnt;
  assign mem_en    = (fetch_gnt && !f_oor) || (dbg_gnt && !d_oor);
  assign mem_we    = dbg_gnt && !d_oor && dbg_we;
  assign mem_addr  = dbg_gnt ? dbg_addr[AW+1:2] : fetch_addr[AW+1:2];
  assign mem_wdata = dbg_wdata;
  // memory data arrives in the rvalid cycle, so rdata passes it through then and holds it afterwards
  assign fetch_rdata = fetch_rvalid ? (f_nop_q ? NOP_WORD : mem_rdata) : f_hold;
  assign dbg_rdata   = dbg_rvalid ? (d_zero_q ? 32'h0 : mem_rdata) : d_hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      core_hold    <= 1'b1;
      wait_cnt     <= '0;
      fetch_rvalid <= 1'b0;
      fetch_err    <= 1'b0;
      dbg_rvalid   <= 1'b0;
      f_nop_q      <= 1'b0;
      d_zero_q     <= 1'b0;
      f_hold       <= '0;
      d_hold       <= '0;
    end else begin
      if (boot && boot_done) begin
        state     <= RUN;
        core_hold <= 1'b0;
      end
      wait_cnt     <= (!dbg_req || dbg_gnt) ? '0 :
                      (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + WW'(1);
      fetch_rvalid <= fetch_gnt;
      fetch_err    <= fetch_gnt && fetch_addr[1:0] != 2'b00;
      f_nop_q      <= f_oor;
      dbg_rvalid   <= dbg_gnt;
      d_zero_q     <= dbg_we || d_oor;
      if (fetch_rvalid) f_hold <= fetch_rdata;
      if (dbg_rvalid) d_hold <= dbg_rdata;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: table-driven + scoreboard bench for imem_arbiter
module tb_imem_arbiter;
  logic        clk = 1'b0, rst = 1'b1, boot_done = 1'b0;
  logic        fetch_req = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] fetch_addr = '0, dbg_addr = '0, dbg_wdata = '0;
  logic        core_hold, fetch_gnt, fetch_rvalid, fetch_err, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  logic [31:0] fetch_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  always #5 clk = ~clk;
  imem_arbiter dut (
    .clk(clk), .rst(rst), .boot_done(boot_done), .core_hold(core_hold),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else mem_rdata <= mem[mem_addr];
    end
  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  typedef struct {logic [31:0] data; logic err;} resp_t;
  resp_t       fq[$];
  logic [31:0] dq[$];
  resp_t       mr;
  logic [31:0] md;
  always @(negedge clk) begin
    if (fq.size() != 0) begin
      mr = fq.pop_front();
      chk("fetch_rvalid", {31'b0, fetch_rvalid}, 32'd1);
      chk("fetch_rdata", fetch_rdata, mr.data);
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, mr.err});
    end else if (fetch_rvalid) chk("fetch_rvalid_unexpected", {31'b0, fetch_rvalid}, 32'd0);
    if (dq.size() != 0) begin
      md = dq.pop_front();
      chk("dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
      chk("dbg_rdata", dbg_rdata, md);
    end else if (dbg_rvalid) chk("dbg_rvalid_unexpected", {31'b0, dbg_rvalid}, 32'd0);
  end
  task automatic step(input logic rs, input logic bd, input logic fr, input logic [31:0] fa,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    resp_t r;
    @(negedge clk);
    rst = rs; boot_done = bd; fetch_req = fr; fetch_addr = fa;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #1;
    if (!rs && fetch_gnt) begin
      r.data = (fa[31:2] >= 30'd256) ? 32'h00000013 : ref_mem[fa[9:2]];
      r.err  = fa[1:0] != 2'b00;
      fq.push_back(r);
    end
    if (!rs && dbg_gnt) begin
      if (da[31:2] >= 30'd256) dq.push_back(32'h0);
      else if (dw) begin
        ref_mem[da[9:2]] = dd;
        dq.push_back(32'h0);
      end else dq.push_back(ref_mem[da[9:2]]);
    end
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask
  typedef struct {
    logic fr; logic [31:0] fa; logic dr, dw; logic [31:0] da, dd;
    logic efg, edg, emen, emwe; logic [7:0] ema;
  } vec_t;
  vec_t vt[18];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{1'b1, 32'h0,     1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vt[1]  = '{1'b1, 32'h4,     1'b1, 1'b0, 32'h8,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    vt[2]  = '{1'b1, 32'h8,     1'b1, 1'b0, 32'h8,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'd2};
    vt[3]  = '{1'b1, 32'hC,     1'b1, 1'b0, 32'h8,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'd3};
    vt[4]  = '{1'b1, 32'h10,    1'b1, 1'b0, 32'h8,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'd4};
    vt[5]  = '{1'b1, 32'h14,    1'b1, 1'b0, 32'h8,        32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
    vt[6]  = '{1'b1, 32'h14,    1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'd5};
    vt[7]  = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h20,       32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 8'd8};
    vt[8]  = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 8'd8};
    vt[9]  = '{1'b1, 32'h400,   1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vt[10] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h400,      32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vt[11] = '{1'b1, 32'h0,     1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vt[12] = '{1'b1, 32'h6,     1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    vt[13] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h9,        32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
    vt[14] = '{1'b1, 32'h10000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vt[15] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vt[16] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h3FC,      32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 1'b1, 8'd255};
    vt[17] = '{1'b1, 32'h3FC,   1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'd255};
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    chk("rst_core_hold", {31'b0, core_hold}, 32'd1);
    chk("rst_fetch_rvalid", {31'b0, fetch_rvalid}, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("rst_fetch_rdata", fetch_rdata, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'(i * 4), 32'h00500093 ^ (32'(i) << 20));
      chk("boot_fetch_gnt", {31'b0, fetch_gnt}, 32'd0);
      chk("boot_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
      chk("boot_mem_we", {31'b0, mem_en & mem_we}, 32'd1);
      chk("boot_mem_addr", {24'b0, mem_addr}, 32'(i));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("boot_fetch_only_gnt", {31'b0, fetch_gnt}, 32'd0);
      chk("boot_fetch_only_mem_en", {31'b0, mem_en}, 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("bootdone_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("bootdone_core_hold", {31'b0, core_hold}, 32'd1);
    idle();
    chk("run_core_hold", {31'b0, core_hold}, 32'd0);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b0, vt[i].fr, vt[i].fa, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
      chk($sformatf("v%0d_fetch_gnt", i), {31'b0, fetch_gnt}, {31'b0, vt[i].efg});
      chk($sformatf("v%0d_dbg_gnt", i), {31'b0, dbg_gnt}, {31'b0, vt[i].edg});
      chk($sformatf("v%0d_mem_en", i), {31'b0, mem_en}, {31'b0, vt[i].emen});
      chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vt[i].emwe});
      if (vt[i].emen) chk($sformatf("v%0d_mem_addr", i), {24'b0, mem_addr}, {24'b0, vt[i].ema});
    end
    idle();
    idle();
    chk("hold_fetch_rdata", fetch_rdata, 32'hCAFEF00D);
    chk("hold_fetch_rvalid", {31'b0, fetch_rvalid}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    chk("pre_rst_fetch_gnt", {31'b0, fetch_gnt}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("post_rst_core_hold", {31'b0, core_hold}, 32'd1);
    chk("post_rst_fetch_gnt", {31'b0, fetch_gnt}, 32'd0);
    chk("post_rst_fetch_rvalid", {31'b0, fetch_rvalid}, 32'd0);
    chk("post_rst_fetch_rdata", fetch_rdata, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'(k * 4), k < 5, 1'b0, 32'h4, 32'h0);
      chk($sformatf("age%0d_dbg_gnt", k), {31'b0, dbg_gnt}, {31'b0, k == 4});
      chk($sformatf("age%0d_fetch_gnt", k), {31'b0, fetch_gnt}, {31'b0, k != 4});
    end
    idle();
    idle();
    chk("scoreboard_fetch_drained", 32'(fq.size()), 32'd0);
    chk("scoreboard_dbg_drained", 32'(dq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
